// File: rtl/placar_pkg.sv
// placar_pkg: shared definitions for the score/lives board.
//   - estado_t       : game state encoding (JOGANDO, FIM)
//   - SEG_BLANK      : all segments off (active-low)
//   - SEG_ZERO       : digit "0" pattern
//   - BLINK_DIV_DEFAULT : CLOCK_50 cycles per LEDR toggle at 50 MHz (4 Hz)
//   - seg7()         : BCD digit -> active-low segments {g,f,e,d,c,b,a}
package placar_pkg;

    typedef enum logic {
        JOGANDO = 1'b0,
        FIM     = 1'b1
    } estado_t;

    localparam logic [6:0] SEG_BLANK         = 7'h7F;
    localparam logic [6:0] SEG_ZERO          = 7'h40;
    localparam int         BLINK_DIV_DEFAULT = 12_500_000;

    // Non-decimal codes never reach the displays; they show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/placar_if.sv
// placar_if: game-event inputs and display outputs of the score board.
//   pausa, inimigo_vivo_array, nave_atingida : game events into the board
//   HEX0..HEX5, LEDR, perdeu                 : registered display outputs
// master = game/test side, slave = the placar block.
interface placar_if #(
    parameter int N_INIMIGOS = 5
);
    logic                  pausa;
    logic [N_INIMIGOS-1:0] inimigo_vivo_array;
    logic                  nave_atingida;
    logic [6:0]            HEX0;
    logic [6:0]            HEX1;
    logic [6:0]            HEX2;
    logic [6:0]            HEX3;
    logic [6:0]            HEX4;
    logic [6:0]            HEX5;
    logic [9:0]            LEDR;
    logic                  perdeu;

    modport master (
        output pausa, inimigo_vivo_array, nave_atingida,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR, perdeu
    );

    modport slave (
        input  pausa, inimigo_vivo_array, nave_atingida,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR, perdeu
    );
endinterface

// File: rtl/placar_hex7seg.sv
// hex7seg: combinational BCD digit (0..9) to active-low 7-segment pattern.
//   i_digit : BCD digit
//   o_seg   : segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg
    import placar_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    assign o_seg = seg7(i_digit);
endmodule

// File: rtl/placar.sv
// placar: score and lives board for the game.
//   CLOCK_50 : system clock, all state on its rising edge
//   reset    : synchronous, active-high
//   bus      : placar_if.slave (game events in, HEX/LEDR/perdeu out)
// Kills are falling bits of inimigo_vivo_array; they queue in a saturating
// pending counter and are credited one per cycle as PONTOS in BCD.
module placar
    import placar_pkg::*;
#(
    parameter int N_INIMIGOS     = 5,
    parameter int VIDAS_INICIAIS = 3,
    parameter int PONTOS         = 10,
    parameter int BLINK_DIV      = BLINK_DIV_DEFAULT
) (
    input  logic     CLOCK_50,
    input  logic     reset,
    placar_if.slave  bus
);
    localparam int KW    = $clog2(N_INIMIGOS + 1);
    localparam int CNT_W = $clog2(BLINK_DIV + 1);
    // PONTOS split into BCD digits, units in [0]
    localparam logic [3:0][3:0] P_BCD = {4'd0, 4'd0, 4'(PONTOS / 10), 4'(PONTOS % 10)};

    estado_t               r_estado;
    logic [3:0][3:0]       r_score;
    logic [3:0]            r_vidas;
    logic [2:0]            r_pend;
    logic [N_INIMIGOS-1:0] r_prev;
    logic [CNT_W-1:0]      r_blink_cnt;
    logic [9:0]            r_ledr;
    logic                  r_perdeu;
    logic [6:0]            r_hex [6];

    logic [N_INIMIGOS-1:0] w_kill_mask;
    logic [KW-1:0]         w_kills;
    logic                  w_credit;
    logic                  w_hit;
    logic [7:0]            w_pend_sum;
    logic [2:0]            w_pend_next;
    logic [3:0][3:0]       w_sum;
    logic [3:0][3:0]       w_score_next;
    logic [4:0]            w_dig;
    logic                  w_carry;
    logic [6:0]            w_seg [5];

    // Only 1->0 transitions count; respawns (0->1) are masked out.
    assign w_kill_mask = r_prev & ~bus.inimigo_vivo_array;

    always_comb begin
        w_kills = '0;
        for (int k = 0; k < N_INIMIGOS; k++) begin
            w_kills = w_kills + KW'(w_kill_mask[k]);
        end
    end

    assign w_credit = (r_pend != 3'd0) && (r_estado == JOGANDO) && !bus.pausa;
    assign w_hit    = bus.nave_atingida && !bus.pausa && (r_estado == JOGANDO);

    // Credit is only taken when pend > 0, so the sum cannot underflow.
    assign w_pend_sum  = 8'(r_pend) + 8'(w_kills) - 8'(w_credit);
    assign w_pend_next = (w_pend_sum > 8'd7) ? 3'd7 : w_pend_sum[2:0];

    // Digit-serial BCD add; a carry out of the thousands saturates at 9999.
    always_comb begin
        w_sum   = '0;
        w_carry = 1'b0;
        w_dig   = '0;
        for (int d = 0; d < 4; d++) begin
            w_dig = 5'(r_score[d]) + 5'(P_BCD[d]) + 5'(w_carry);
            if (w_dig > 5'd9) begin
                w_sum[d] = 4'(w_dig - 5'd10);
                w_carry  = 1'b1;
            end else begin
                w_sum[d] = w_dig[3:0];
                w_carry  = 1'b0;
            end
        end
        w_score_next = w_carry ? {4{4'd9}} : w_sum;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_estado    <= JOGANDO;
            r_score     <= '0;
            r_vidas     <= 4'(VIDAS_INICIAIS);
            r_pend      <= 3'd0;
            r_prev      <= '1;
            r_blink_cnt <= '0;
            r_ledr      <= '0;
            r_perdeu    <= 1'b0;
        end else begin
            r_prev <= bus.inimigo_vivo_array;
            case (r_estado)
                JOGANDO: begin
                    r_pend <= w_pend_next;
                    if (w_credit) begin
                        r_score <= w_score_next;
                    end
                    if (w_hit) begin
                        r_vidas <= r_vidas - 4'd1;
                        // Last life: enter FIM with LEDR lit on this same edge.
                        if (r_vidas == 4'd1) begin
                            r_estado    <= FIM;
                            r_perdeu    <= 1'b1;
                            r_ledr      <= '1;
                            r_blink_cnt <= '0;
                        end
                    end
                end
                FIM: begin
                    r_pend <= 3'd0;
                    if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                        r_blink_cnt <= '0;
                        r_ledr      <= ~r_ledr;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                default: r_estado <= JOGANDO;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_score_seg
            hex7seg u_seg (
                .i_digit (r_score[gi]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

    hex7seg u_seg_vidas (
        .i_digit (r_vidas),
        .o_seg   (w_seg[4])
    );

    // Display registers trail the score/lives registers by one edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int h = 0; h < 4; h++) begin
                r_hex[h] <= SEG_ZERO;
            end
            r_hex[4] <= SEG_BLANK;
            r_hex[5] <= seg7(4'(VIDAS_INICIAIS));
        end else begin
            for (int h = 0; h < 4; h++) begin
                r_hex[h] <= w_seg[h];
            end
            r_hex[4] <= SEG_BLANK;
            r_hex[5] <= w_seg[4];
        end
    end

    assign bus.HEX0   = r_hex[0];
    assign bus.HEX1   = r_hex[1];
    assign bus.HEX2   = r_hex[2];
    assign bus.HEX3   = r_hex[3];
    assign bus.HEX4   = r_hex[4];
    assign bus.HEX5   = r_hex[5];
    assign bus.LEDR   = r_ledr;
    assign bus.perdeu = r_perdeu;

endmodule

// File: tb/tb_placar.sv
// tb_placar: self-checking bench for placar (PONTOS=10, 3 lives, BLINK_DIV=4).
// Expected displayed scores are queued as kills are driven and popped by a
// monitor whenever the four score digits change on the displays.
module tb_placar;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    placar_if #(.N_INIMIGOS(5)) bus ();

    placar #(
        .N_INIMIGOS     (5),
        .VIDAS_INICIAIS (3),
        .PONTOS         (10),
        .BLINK_DIV      (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int model_score = 0;
    int last_score  = 0;
    bit mon_en      = 1'b0;

    function automatic int seg2dig(input logic [6:0] s);
        case (s)
            7'h40: return 0;
            7'h79: return 1;
            7'h24: return 2;
            7'h30: return 3;
            7'h19: return 4;
            7'h12: return 5;
            7'h02: return 6;
            7'h78: return 7;
            7'h00: return 8;
            7'h10: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic int shown_score();
        int d0, d1, d2, d3;
        d0 = seg2dig(bus.HEX0);
        d1 = seg2dig(bus.HEX1);
        d2 = seg2dig(bus.HEX2);
        d3 = seg2dig(bus.HEX3);
        if (d0 < 0 || d1 < 0 || d2 < 0 || d3 < 0) return -1;
        return d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    endfunction

    // Scoreboard monitor: every change of the displayed score must match the
    // next queued expectation.
    always @(negedge clk) begin
        int cur;
        int e;
        if (mon_en) begin
            cur = shown_score();
            if (cur != last_score) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL score_unexpected: got %0d, required %0d", cur, last_score);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        failures++;
                        $display("FAIL score_seq: got %0d, required %0d", cur, e);
                    end else begin
                        $display("score update %0d", cur);
                    end
                end
                last_score = cur;
            end
        end
    end

    task automatic kill_model(input int n);
        int nxt;
        for (int i = 0; i < n; i++) begin
            nxt = (model_score + 10 > 9999) ? 9999 : model_score + 10;
            if (nxt != model_score) exp_q.push_back(nxt);
            model_score = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        logic [6:0] hx [4];
        hx[0] = bus.HEX0; hx[1] = bus.HEX1; hx[2] = bus.HEX2; hx[3] = bus.HEX3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hx[i] !== 7'h40) begin
                failures++;
                $display("FAIL %s_hex%0d: got %h, required 40", tag, i, hx[i]);
            end
        end
        checks++;
        if (bus.HEX4 !== 7'h7F) begin failures++; $display("FAIL %s_hex4: got %h, required 7f", tag, bus.HEX4); end
        checks++;
        if (bus.HEX5 !== 7'h30) begin failures++; $display("FAIL %s_hex5: got %h, required 30", tag, bus.HEX5); end
        checks++;
        if (bus.LEDR !== 10'h000) begin failures++; $display("FAIL %s_ledr: got %h, required 000", tag, bus.LEDR); end
        checks++;
        if (bus.perdeu !== 1'b0) begin failures++; $display("FAIL %s_perdeu: got %b, required 0", tag, bus.perdeu); end
        $display("%s: reset values inspected", tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pausa = 1'b0;
        bus.nave_atingida = 1'b0;
        bus.inimigo_vivo_array = 5'b11111;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        model_score = 0;
        last_score = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_kill();
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11011;
        kill_model(1);
        tick();
        checks++;
        if (bus.HEX1 !== 7'h40) begin failures++; $display("FAIL latency_e1: got %h, required 40", bus.HEX1); end
        tick();
        checks++;
        if (bus.HEX1 !== 7'h40) begin failures++; $display("FAIL latency_e2: got %h, required 40", bus.HEX1); end
        tick();
        checks++;
        if (bus.HEX1 !== 7'h79) begin failures++; $display("FAIL latency_e3: got %h, required 79", bus.HEX1); end
        $display("single kill: HEX1 %h", bus.HEX1);
        // Respawn must not be counted as a kill.
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11111;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_multi_kill();
        logic [6:0] exp_h1 [3];
        exp_h1[0] = 7'h24; exp_h1[1] = 7'h30; exp_h1[2] = 7'h19;
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11000;
        kill_model(3);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.HEX1 !== exp_h1[i]) begin
                failures++;
                $display("FAIL multi_kill_step%0d: got %h, required %h", i, bus.HEX1, exp_h1[i]);
            end
            $display("multi kill step %0d: HEX1 %h", i, bus.HEX1);
        end
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11111;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pause();
        @(negedge clk);
        bus.pausa = 1'b1;
        bus.inimigo_vivo_array = 5'b11110;
        bus.nave_atingida = 1'b1;
        @(negedge clk);
        bus.nave_atingida = 1'b0;
        bus.inimigo_vivo_array = 5'b11111;
        repeat (4) @(negedge clk);
        checks++;
        if (shown_score() != 40) begin failures++; $display("FAIL pause_score: got %0d, required 40", shown_score()); end
        checks++;
        if (bus.HEX5 !== 7'h30) begin failures++; $display("FAIL pause_lives: got %h, required 30", bus.HEX5); end
        bus.pausa = 1'b0;
        kill_model(1);
        tick();
        tick();
        checks++;
        if (shown_score() != 50) begin failures++; $display("FAIL unpause_score: got %0d, required 50", shown_score()); end
        checks++;
        if (bus.HEX5 !== 7'h30) begin failures++; $display("FAIL unpause_lives: got %h, required 30", bus.HEX5); end
        $display("pause: score %0d lives seg %h", shown_score(), bus.HEX5);
    endtask

    task automatic test_hits_to_fim();
        logic [6:0] exp_l [2];
        exp_l[0] = 7'h24; exp_l[1] = 7'h79;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.nave_atingida = 1'b1;
            @(negedge clk);
            bus.nave_atingida = 1'b0;
            tick();
            checks++;
            if (bus.HEX5 !== exp_l[i]) begin failures++; $display("FAIL hit%0d_lives: got %h, required %h", i, bus.HEX5, exp_l[i]); end
            $display("hit %0d: HEX5 %h", i, bus.HEX5);
        end
        // Kill one cycle before the final hit: its credit lands on the FIM edge.
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11101;
        kill_model(1);
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11111;
        bus.nave_atingida = 1'b1;
        tick();
        checks++;
        if (bus.perdeu !== 1'b1) begin failures++; $display("FAIL fim_perdeu: got %b, required 1", bus.perdeu); end
        checks++;
        if (bus.LEDR !== 10'h3FF) begin failures++; $display("FAIL fim_ledr_on: got %h, required 3ff", bus.LEDR); end
        @(negedge clk);
        bus.nave_atingida = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.LEDR !== 10'h3FF) begin failures++; $display("FAIL blink_hold: got %h, required 3ff", bus.LEDR); end
        tick();
        checks++;
        if (bus.LEDR !== 10'h000) begin failures++; $display("FAIL blink_off: got %h, required 000", bus.LEDR); end
        checks++;
        if (bus.HEX5 !== 7'h40) begin failures++; $display("FAIL fim_lives: got %h, required 40", bus.HEX5); end
        $display("fim: perdeu %b LEDR %h HEX5 %h", bus.perdeu, bus.LEDR, bus.HEX5);
    endtask

    task automatic test_fim_frozen();
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b00000;
        bus.nave_atingida = 1'b1;
        @(negedge clk);
        bus.nave_atingida = 1'b0;
        bus.inimigo_vivo_array = 5'b11111;
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b00000;
        repeat (5) @(negedge clk);
        checks++;
        if (shown_score() != 60) begin failures++; $display("FAIL fim_score: got %0d, required 60", shown_score()); end
        checks++;
        if (bus.HEX5 !== 7'h40) begin failures++; $display("FAIL fim_lives_frozen: got %h, required 40", bus.HEX5); end
        checks++;
        if (bus.perdeu !== 1'b1) begin failures++; $display("FAIL fim_perdeu_held: got %b, required 1", bus.perdeu); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL fim_queue: got %0d pending, required 0", exp_q.size()); end
        // One-cycle reset returns to the initial display state.
        mon_en = 1'b0;
        rst = 1'b1;
        bus.inimigo_vivo_array = 5'b11111;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rereset");
        model_score = 0;
        last_score = 0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 1002; i++) begin
            @(negedge clk);
            bus.inimigo_vivo_array = 5'b11110;
            kill_model(1);
            @(negedge clk);
            bus.inimigo_vivo_array = 5'b11111;
        end
        // A burst of five kills at the ceiling must also hold.
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b00000;
        kill_model(5);
        @(negedge clk);
        bus.inimigo_vivo_array = 5'b11111;
        repeat (10) @(negedge clk);
        checks++;
        if (shown_score() != 9999) begin failures++; $display("FAIL saturate: got %0d, required 9999", shown_score()); end
        $display("saturation: score %0d", shown_score());
    endtask

    initial begin
        test_reset();
        test_single_kill();
        test_multi_kill();
        test_pause();
        test_hits_to_fim();
        test_fim_frozen();
        test_saturation();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
